fp16_addsub_sequencer: RTL and testbench

- Multi-cycle controller and datapath sequencer for IEEE-754 binary16 add/subtract.
- Accepts one operand pair over a valid/ready handshake. Orders the operands by magnitude, then steps through alignment, add/subtract, normalisation and packing, one shift per cycle.
- Presents the result over a valid/ready handshake.
- Serves as the shared FP16 add unit behind the simulator's ALU front-end. One operation is in flight at a time.

---
 rtl/fp16_pkg.sv | 36 +++
 rtl/fp16_classify.sv | 23 ++
 rtl/fp16_addsub_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_fp16_addsub_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared binary16 field widths, constants, sequencer states and flag bit positions
// used by the FP16 add/subtract sequencer and its operand classifier.
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int SIG_W = 14;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    PACK,
    DONE
  } state_e;

  // Positions inside flags = {invalid, overflow, underflow, inexact}
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
    logic is_sub;
  } fp16_class_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational NaN/Inf/zero/subnormal decode of one binary16 magnitude.
// Subnormals report is_zero as well, since the sequencer flushes them.
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [EXP_W+MAN_W-1:0] mag_i,
  output fp16_class_t            class_o
);

  logic [EXP_W-1:0] exp_f;
  logic             man_nz;

  assign exp_f  = mag_i[EXP_W+MAN_W-1:MAN_W];
  assign man_nz = |mag_i[MAN_W-1:0];

  always_comb begin
    class_o.is_nan  = (exp_f == EXP_MAX) && man_nz;
    class_o.is_inf  = (exp_f == EXP_MAX) && !man_nz;
    class_o.is_zero = (exp_f == '0);
    class_o.is_sub  = (exp_f == '0) && man_nz;
  end

endmodule

// File: rtl/fp16_addsub_sequencer.sv
// Multi-cycle binary16 add/subtract: accept, align, add, normalise, pack, one shift per cycle.
// Define FP16_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results are truncated.
module fp16_addsub_sequencer
  import fp16_pkg::*;
#(
  parameter int unsigned ALIGN_CLAMP = 14,
  parameter logic [15:0] NAN_VALUE   = FP16_QNAN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [3:0]  flags
);

  localparam logic [EXP_W-1:0] EXP_LAST = EXP_MAX - 5'd1;

  state_e             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [15:0]        result_q;
  logic [3:0]         flags_q;
  logic               sign_q;
  logic               eff_sub_q;
  logic [EXP_W-1:0]   exp_q;
  logic [SIG_W-1:0]   big_q;
  logic [SIG_W-1:0]   small_q;
  logic [3:0]         shift_q;
  logic [SIG_W:0]     sum_q;

  fp16_class_t        cls_a;
  fp16_class_t        cls_b;
  logic               a_sign;
  logic               b_sign;
  logic [14:0]        a_mag;
  logic [14:0]        b_mag;
  logic               a_is_big;
  logic [14:0]        big_mag;
  logic [14:0]        small_mag;
  logic [EXP_W-1:0]   exp_diff;
  logic [3:0]         shift_init;
  logic               special;
  logic [15:0]        spec_res;
  logic [3:0]         spec_flags;
  logic               round_up;
  logic [EXP_W+MAN_W-1:0] rounded;

  assign a_sign = op_a[15];
  assign b_sign = op_b[15] ^ sub;
  assign a_mag  = op_a[14:0];
  assign b_mag  = op_b[14:0];

  fp16_classify u_class_a (.mag_i(a_mag), .class_o(cls_a));
  fp16_classify u_class_b (.mag_i(b_mag), .class_o(cls_b));

  assign a_is_big  = (a_mag >= b_mag);
  assign big_mag   = a_is_big ? a_mag : b_mag;
  assign small_mag = a_is_big ? b_mag : a_mag;
  assign exp_diff  = big_mag[14:10] - small_mag[14:10];
  assign shift_init = ({27'd0, exp_diff} > ALIGN_CLAMP) ? 4'(ALIGN_CLAMP) : exp_diff[3:0];

  // Special operands resolve straight from the inputs and skip the datapath.
  always_comb begin
    special    = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    spec_flags[FLAG_INEXACT] = cls_a.is_sub | cls_b.is_sub;
    if (cls_a.is_nan || cls_b.is_nan) begin
      spec_res = NAN_VALUE;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (cls_a.is_inf && cls_b.is_inf) begin
      if (a_sign != b_sign) begin
        spec_res = NAN_VALUE;
        spec_flags[FLAG_INVALID] = 1'b1;
      end else begin
        spec_res = {a_sign, FP16_PINF[14:0]};
      end
    end else if (cls_a.is_inf) begin
      spec_res = {a_sign, a_mag};
    end else if (cls_b.is_inf) begin
      spec_res = {b_sign, b_mag};
    end else if (cls_a.is_zero && cls_b.is_zero) begin
      spec_res = {a_sign & b_sign, 15'd0};
    end else if (cls_a.is_zero) begin
      spec_res = {b_sign, b_mag};
    end else if (cls_b.is_zero) begin
      spec_res = {a_sign, a_mag};
    end else if ((a_mag == b_mag) && (a_sign != b_sign)) begin
      spec_res = '0;
    end else begin
      special = 1'b0;
    end
  end

  // A mantissa carry out of the rounding increment ripples into the exponent field.
  always_comb begin
`ifdef FP16_ROUND_NEAREST_EN
    round_up = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
`else
    round_up = 1'b0;
`endif
    rounded = {exp_q, sum_q[12:3]} + {{(EXP_W+MAN_W-1){1'b0}}, round_up};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      sign_q      <= 1'b0;
      eff_sub_q   <= 1'b0;
      exp_q       <= '0;
      big_q       <= '0;
      small_q     <= '0;
      shift_q     <= '0;
      sum_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (special) begin
              result_q    <= spec_res;
              flags_q     <= spec_flags;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              sign_q    <= a_is_big ? a_sign : b_sign;
              eff_sub_q <= a_sign ^ b_sign;
              exp_q     <= big_mag[14:10];
              big_q     <= {1'b1, big_mag[9:0], 3'b000};
              small_q   <= {1'b1, small_mag[9:0], 3'b000};
              shift_q   <= shift_init;
              flags_q   <= '0;
              state_q   <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (shift_q == 4'd0) begin
            state_q <= ADD;
          end else begin
            small_q <= {1'b0, small_q[SIG_W-1:2], small_q[1] | small_q[0]};
            shift_q <= shift_q - 4'd1;
          end
        end
        ADD: begin
          sum_q   <= eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                               : ({1'b0, big_q} + {1'b0, small_q});
          state_q <= NORM;
        end
        NORM: begin
          if (sum_q[SIG_W]) begin
            sum_q <= {1'b0, sum_q[SIG_W:2], sum_q[1] | sum_q[0]};
            if (exp_q == EXP_LAST) begin
              result_q    <= {sign_q, FP16_PINF[14:0]};
              flags_q     <= 4'b0101;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              exp_q   <= exp_q + 5'd1;
              state_q <= PACK;
            end
          end else if (!sum_q[SIG_W-1]) begin
            sum_q <= {sum_q[SIG_W-1:0], 1'b0};
            if (exp_q == 5'd1) begin
              result_q    <= {sign_q, 15'd0};
              flags_q     <= 4'b0011;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              exp_q <= exp_q - 5'd1;
              if (sum_q[SIG_W-2]) begin
                state_q <= PACK;
              end
            end
          end else begin
            state_q <= PACK;
          end
        end
        PACK: begin
          if (rounded[14:10] == EXP_MAX) begin
            result_q <= {sign_q, FP16_PINF[14:0]};
            flags_q  <= 4'b0101;
          end else begin
            result_q <= {sign_q, rounded};
            flags_q  <= {3'b000, |sum_q[2:0]};
          end
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp16_addsub_sequencer.sv
// Self-checking bench for fp16_addsub_sequencer: scoreboard queue of expected {result, flags}.
// Honours FP16_ROUND_NEAREST_EN for the rounding expectations.
module tb_fp16_addsub_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] exp_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] r;
    logic [3:0]  f;
  } vec_t;

`ifdef FP16_ROUND_NEAREST_EN
  localparam logic [15:0] R_1P_1200 = 16'h3C01;
  localparam logic [15:0] R_3C01_1000 = 16'h3C02;
`else
  localparam logic [15:0] R_1P_1200 = 16'h3C00;
  localparam logic [15:0] R_3C01_1000 = 16'h3C01;
`endif

  always #5 clk = ~clk;

  fp16_addsub_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  // Present an operand pair and return at the negedge after the accepting edge.
  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic s, output bit to);
    int n;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    to = !in_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [15:0] res, output logic [3:0] flg, output int lat, output bit to);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    to = !out_valid;
    res = result;
    flg = flags;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        output logic [15:0] res, output logic [3:0] flg, output int lat, output bit to);
    bit to_in;
    accept(a, b, s, to_in);
    wait_out(res, flg, lat, to);
    to = to | to_in;
    release_out();
    $display("op %h %s %h -> %h flags %b latency %0d", a, s ? "-" : "+", b, res, flg, lat);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if ({result, flags} !== 20'h0) begin n_fail++; $display("FAIL reset_result_flags: got %h/%b want 0000/0000", result, flags); end
    $display("reset: in_ready %b out_valid %b result %h flags %b", in_ready, out_valid, result, flags);
  endtask

  task automatic test_basic();
    logic [15:0] res; logic [3:0] flg; int lat; bit to; logic [19:0] e;
    exp_q.push_back({16'h4000, 4'h0});
    run_op(16'h3C00, 16'h3C00, 1'b0, res, flg, lat, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || {res, flg} !== e) begin n_fail++; $display("FAIL add_1p1: got %h/%b want %h/%b", res, flg, e[19:4], e[3:0]); end
    n_checks++;
    if (lat != 5) begin n_fail++; $display("FAIL add_1p1_latency: got %0d want 5", lat); end
    exp_q.push_back({16'h0000, 4'h0});
    run_op(16'h3C00, 16'h3C00, 1'b1, res, flg, lat, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || {res, flg} !== e) begin n_fail++; $display("FAIL sub_1m1: got %h/%b want %h/%b", res, flg, e[19:4], e[3:0]); end
    n_checks++;
    if (lat != 1) begin n_fail++; $display("FAIL sub_1m1_latency: got %0d want 1", lat); end
  endtask

  task automatic test_vectors();
    vec_t v[$];
    logic [15:0] res; logic [3:0] flg; int lat; bit to; logic [19:0] e;
    v.push_back('{16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 4'b1000});
    v.push_back('{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101});
    v.push_back('{16'h7C01, 16'h3C00, 1'b0, 16'h7E00, 4'b1000});
    v.push_back('{16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 4'b0000});
    v.push_back('{16'h7C00, 16'hFC00, 1'b1, 16'h7C00, 4'b0000});
    v.push_back('{16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0000});
    v.push_back('{16'h0000, 16'h0000, 1'b1, 16'h0000, 4'b0000});
    v.push_back('{16'h0000, 16'h3C00, 1'b1, 16'hBC00, 4'b0000});
    v.push_back('{16'h3C00, 16'h0000, 1'b1, 16'h3C00, 4'b0000});
    v.push_back('{16'h0001, 16'h3C00, 1'b0, 16'h3C00, 4'b0001});
    v.push_back('{16'h0401, 16'h0400, 1'b1, 16'h0000, 4'b0011});
    v.push_back('{16'h7BFF, 16'h5000, 1'b0, 16'h7C00, 4'b0101});
    v.push_back('{16'h4000, 16'h3C00, 1'b1, 16'h3C00, 4'b0000});
    v.push_back('{16'h3C00, 16'hC000, 1'b0, 16'hBC00, 4'b0000});
    v.push_back('{16'h3C00, 16'h3800, 1'b0, 16'h3E00, 4'b0000});
    v.push_back('{16'h5000, 16'h0400, 1'b0, 16'h5000, 4'b0001});
    foreach (v[i]) begin
      exp_q.push_back({v[i].r, v[i].f});
      run_op(v[i].a, v[i].b, v[i].s, res, flg, lat, to);
      e = exp_q.pop_front();
      n_checks++;
      if (to || {res, flg} !== e) begin
        n_fail++;
        $display("FAIL vec%0d %h%s%h: got %h/%b want %h/%b", i, v[i].a, v[i].s ? "-" : "+", v[i].b, res, flg, e[19:4], e[3:0]);
      end
    end
  endtask

  task automatic test_rounding();
    vec_t v[$];
    logic [15:0] res; logic [3:0] flg; int lat; bit to; logic [19:0] e;
    v.push_back('{16'h3C00, 16'h1200, 1'b0, R_1P_1200, 4'b0001});
    v.push_back('{16'h3C01, 16'h1000, 1'b0, R_3C01_1000, 4'b0001});
    v.push_back('{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0001});
    foreach (v[i]) begin
      exp_q.push_back({v[i].r, v[i].f});
      run_op(v[i].a, v[i].b, v[i].s, res, flg, lat, to);
      e = exp_q.pop_front();
      n_checks++;
      if (to || {res, flg} !== e) begin
        n_fail++;
        $display("FAIL round%0d %h+%h: got %h/%b want %h/%b", i, v[i].a, v[i].b, res, flg, e[19:4], e[3:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] res; logic [3:0] flg; int lat; bit to, to2; logic [19:0] e;
    bit stable; bit ir_seen;
    exp_q.push_back({16'h4200, 4'h0});
    accept(16'h4000, 16'h3C00, 1'b0, to);
    wait_out(res, flg, lat, to2);
    e = exp_q.pop_front();
    op_a = 16'h3C00; op_b = 16'h3C00; sub = 1'b0; in_valid = 1'b1;
    exp_q.push_back({16'h4000, 4'h0});
    stable = 1'b1; ir_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!out_valid || result !== e[19:4] || flags !== e[3:0]) stable = 1'b0;
      if (in_ready) ir_seen = 1'b1;
    end
    n_checks++;
    if (to || to2 || {res, flg} !== e) begin n_fail++; $display("FAIL bp_result: got %h/%b want %h/%b", res, flg, e[19:4], e[3:0]); end
    n_checks++;
    if (!stable) begin n_fail++; $display("FAIL bp_hold: got %h/%b valid %b want %h/%b held", result, flags, out_valid, e[19:4], e[3:0]); end
    n_checks++;
    if (ir_seen) begin n_fail++; $display("FAIL bp_in_ready: got 1 while result held want 0"); end
    $display("op 4000 + 3C00 -> %h flags %b held 5 cycles", res, flg);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_reaccept: got in_ready %b want 0", in_ready); end
    wait_out(res, flg, lat, to);
    release_out();
    e = exp_q.pop_front();
    n_checks++;
    if (to || {res, flg} !== e || lat != 5) begin
      n_fail++; $display("FAIL bp_second: got %h/%b lat %0d want %h/%b lat 5", res, flg, lat, e[19:4], e[3:0]);
    end
    $display("op 3C00 + 3C00 -> %h flags %b latency %0d (queued during hold)", res, flg, lat);
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] res; logic [3:0] flg; int lat; bit to; logic [19:0] e; bit seen;
    accept(16'h5000, 16'h0400, 1'b0, to);
    n_checks++;
    if (to || in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got in_ready %b want 0", in_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || flags !== 4'h0) begin
      n_fail++; $display("FAIL rst_mid_op: got in_ready %b out_valid %b flags %b want 1 0 0000", in_ready, out_valid, flags);
    end
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL rst_dropped: got out_valid 1 after reset want 0"); end
    $display("reset mid-op: in_ready %b out_valid %b flags %b", in_ready, out_valid, flags);
    exp_q.push_back({16'h4000, 4'h0});
    run_op(16'h3C00, 16'h3C00, 1'b0, res, flg, lat, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || {res, flg} !== e) begin n_fail++; $display("FAIL rst_followup: got %h/%b want %h/%b", res, flg, e[19:4], e[3:0]); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_rounding();
    test_backpressure();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
